// File: rtl/fifo_reader_if.sv
// fifo_reader_if: groups the FIFO read port and the downstream valid/ready
// stream of fifo_reader.
//   fifo_rd_en  read strobe to the FIFO
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, registered, valid the cycle after a strobe
//   m_valid     output word available
//   m_data      output word
//   m_ready     downstream accepts m_data this cycle
// master = the reader, slave = FIFO + downstream consumer.
interface fifo_reader_if #(parameter int DW = 8);
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    output fifo_rd_en, m_valid, m_data,
    input  fifo_empty, fifo_rdata, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data,
    output fifo_empty, fifo_rdata, m_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO (one-cycle registered read data)
// into an in-order valid/ready stream through a 3-entry output buffer.
//   clk       rising-edge clock, shared with the FIFO
//   rst       asynchronous active-low reset
//   en        1 = allowed to issue FIFO reads (buffer drains regardless)
//   bus       fifo_reader_if.master: FIFO read port + output stream
//   rd_count  output transfers since reset, wraps mod 2^CNTW
//   idle      nothing buffered, no read in flight, FIFO empty
module fifo_reader #(
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  fifo_reader_if.master   bus,
  output logic [CNTW-1:0] rd_count,
  output logic            idle
);

  logic [2:0][DW-1:0] mem;
  logic [1:0]         wr_idx;
  logic [1:0]         rd_idx;
  logic [1:0]         occ;
  logic               inflight;
  logic               cap;
  logic               xfer;
  logic [2:0]         reserved;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Slots already claimed: buffered words plus the one coming back from the FIFO.
  // Only issue when a slot is guaranteed free at capture time; this keeps
  // m_ready out of the strobe path while still sustaining one word per cycle.
  assign reserved       = {1'b0, occ} + {2'b0, inflight};
  // rst gating keeps the strobe low for the whole reset, not only after an edge.
  assign bus.fifo_rd_en = rst && en && !bus.fifo_empty && (reserved < 3'd3);

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = mem[rd_idx];

  assign cap  = inflight;
  assign xfer = bus.m_valid && bus.m_ready;

  assign idle = (occ == 2'd0) && !inflight && bus.fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem      <= '0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (cap) begin
        mem[wr_idx] <= bus.fifo_rdata;
        wr_idx      <= nxt(wr_idx);
      end
      if (xfer) begin
        rd_idx   <= nxt(rd_idx);
        rd_count <= rd_count + 1'b1;
      end
      case ({cap, xfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] rd_count;
  logic        idle;

  fifo_reader_if #(.DW(8)) bus ();

  fifo_reader #(.DW(8), .CNTW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus.master),
    .rd_count (rd_count),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: 256-deep ring, registered read data.
  logic [7:0] fmem [256];
  int         wptr = 0;
  int         rptr = 0;
  logic       m_ready = 1'b0;

  assign bus.fifo_empty = (wptr == rptr);
  assign bus.m_ready    = m_ready;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr           <= wptr;
      bus.fifo_rdata <= 8'h00;
    end else if (bus.fifo_rd_en) begin
      bus.fifo_rdata <= fmem[rptr % 256];
      rptr           <= rptr + 1;
    end
  end

  // Transfer log and strobe counter.
  logic [7:0] olog [256];
  int         n_out  = 0;
  int         n_strb = 0;

  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      olog[n_out % 256] <= bus.m_data;
      n_out             <= n_out + 1;
    end
    if (bus.fifo_rd_en) n_strb <= n_strb + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wptr % 256] = d;
    wptr = wptr + 1;
  endtask

  int base;
  int s0;
  logic [7:0] w;

  initial begin
    // ---- reset state
    step();
    chk("rst_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid},    32'd0);
    chk("rst_m_data",  {24'd0, bus.m_data},     32'd0);
    chk("rst_count",   {16'd0, rd_count},       32'd0);
    chk("rst_idle",    {31'd0, idle},           32'd1);
    step();
    rst = 1'b1;
    step();

    // ---- three words, full throughput
    base = n_out;
    en = 1'b1; m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    chk("t1_c0_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    step();
    chk("t1_c1_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    chk("t1_c1_valid", {31'd0, bus.m_valid},    32'd0);
    step();
    chk("t1_c2_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    chk("t1_c2_data",  {24'd0, bus.m_data},     32'h11);
    step();
    chk("t1_c3_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("t1_c3_data",  {24'd0, bus.m_data},     32'h22);
    step();
    chk("t1_c4_data",  {24'd0, bus.m_data},     32'h33);
    step();
    chk("t1_c5_valid", {31'd0, bus.m_valid},    32'd0);
    chk("t1_c5_idle",  {31'd0, idle},           32'd1);
    chk("t1_count",    {16'd0, rd_count},       32'd3);
    chk("t1_nout",     n_out - base,            32'd3);

    // ---- back-pressure: 10 words, m_ready low
    m_ready = 1'b0;
    s0 = n_strb;
    for (int i = 0; i < 10; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 6; i++) step();
    chk("t2_strobes", n_strb - s0,             32'd3);
    chk("t2_valid",   {31'd0, bus.m_valid},    32'd1);
    chk("t2_data",    {24'd0, bus.m_data},     32'hB0);
    chk("t2_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    step();
    chk("t2_hold",    {24'd0, bus.m_data},     32'hB0);
    base = n_out;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t2_nout", n_out - base, 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t2_word%0d", i), {24'd0, olog[(base + i) % 256]}, 32'hB0 + i);
    chk("t2_count", {16'd0, rd_count}, 32'd13);
    chk("t2_idle",  {31'd0, idle},     32'd1);

    // ---- m_ready toggling every cycle
    base = n_out;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      m_ready = ~m_ready;
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t3_nout", n_out - base, 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_word%0d", i), {24'd0, olog[(base + i) % 256]}, 32'hA0 + i);
    chk("t3_count", {16'd0, rd_count}, 32'd21);

    // ---- en dropped mid-stream
    base = n_out;
    for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    #1;
    chk("t4_rd_en_off", {31'd0, bus.fifo_rd_en}, 32'd0);
    s0 = n_strb;
    w  = 8'(n_out - base);
    for (int i = 0; i < 3; i++) step();
    chk("t4_no_strobe", n_strb - s0,          32'd0);
    chk("t4_drained",   n_out - base - int'(w), 32'd2);
    en = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("t4_nout", n_out - base, 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("t4_word%0d", i), {24'd0, olog[(base + i) % 256]}, 32'hC0 + i);
    chk("t4_count", {16'd0, rd_count}, 32'd33);

    // ---- asynchronous reset with two words buffered
    m_ready = 1'b0;
    push(8'hD0); push(8'hD1);
    for (int i = 0; i < 5; i++) step();
    chk("t5_valid_pre", {31'd0, bus.m_valid}, 32'd1);
    chk("t5_data_pre",  {24'd0, bus.m_data},  32'hD0);
    push(8'hD2);
    #1;
    chk("t5_rd_en_pre", {31'd0, bus.fifo_rd_en}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_valid_rst", {31'd0, bus.m_valid},    32'd0);
    chk("t5_rd_en_rst", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("t5_count_rst", {16'd0, rd_count},       32'd0);
    chk("t5_data_rst",  {24'd0, bus.m_data},     32'd0);
    step();
    rst = 1'b1;
    step();
    base = n_out;
    m_ready = 1'b1;
    push(8'h5A);
    for (int i = 0; i < 6; i++) step();
    chk("t5_nout",  n_out - base,                    32'd1);
    chk("t5_first", {24'd0, olog[base % 256]},       32'h5A);
    chk("t5_count", {16'd0, rd_count},               32'd1);

    // ---- counter wrap: 65537 transfers from a fresh reset
    rst = 1'b0;
    #1;
    chk("t6_count_rst", {16'd0, rd_count}, 32'd0);
    step();
    rst = 1'b1;
    step();
    base = n_out;
    for (int i = 0; i < 65537; i++) begin
      push(8'(i));
      step();
    end
    for (int i = 0; i < 10; i++) step();
    chk("t6_nout",  n_out - base,                    32'd65537);
    chk("t6_count", {16'd0, rd_count},               32'd1);
    chk("t6_last",  {24'd0, olog[(n_out - 1) % 256]}, 32'h00);
    chk("t6_idle",  {31'd0, idle},                   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
